timestamp_capture: RTL and testbench

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

---
 rtl/timestamp_capture.sv | 133 +++++++++++++
 tb/tb_timestamp_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture.sv
// Event timestamp capture: synchronizes an async event line, stamps each rising edge
// with the timebase, and queues {first, delta, stamp} entries in a small FIFO.
module timestamp_capture #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [31:0]              counter,
   input  logic                     event_in,
   input  logic                     clear_ovf,
   output logic                     ts_valid,
   input  logic                     ts_ready,
   output logic [31:0]              ts_stamp,
   output logic [31:0]              ts_delta,
   output logic                     ts_first,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic        first;
      logic [30:0] delta;
      logic [30:0] stamp;
   } entry_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   edge_q;
   logic                   armed_q;
   logic                   first_q;
   logic [30:0]            last_ts_q;
   logic [AW-1:0]          wr_ptr_q;
   logic [AW-1:0]          rd_ptr_q;
   logic [LW-1:0]          count_q;
   entry_t                 mem [DEPTH];

   logic                   detect_c;
   logic                   full_c;
   logic                   pop_c;
   logic                   push_c;
   logic                   drop_c;
   entry_t                 new_entry_c;
   entry_t                 head_nxt_c;
   logic [AW-1:0]          rd_ptr_nxt_c;
   logic [LW-1:0]          count_nxt_c;

   // fill_q marks when the synchronizer holds real samples; armed_q then waits for a
   // genuine low so a line already high at reset release is not reported as an event.
   always_comb begin
      detect_c     = armed_q & sync_q[SYNC_STAGES-1] & ~edge_q;
      full_c       = (count_q == LW'(DEPTH));
      pop_c        = ts_valid & ts_ready;
      push_c       = detect_c & (~full_c | pop_c);
      drop_c       = detect_c & full_c & ~pop_c;
      new_entry_c.first = first_q;
      new_entry_c.stamp = counter[30:0];
      new_entry_c.delta = first_q ? 31'd0 : (counter[30:0] - last_ts_q);
      rd_ptr_nxt_c = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_nxt_c  = count_q + LW'(push_c) - LW'(pop_c);
      // When the write lands on the next head slot, forward it into the output registers.
      if (push_c && (count_q == LW'(pop_c))) begin
         head_nxt_c = new_entry_c;
      end else begin
         head_nxt_c = mem[rd_ptr_nxt_c];
      end
   end

   always_ff @(posedge clock) begin
      if (push_c) begin
         mem[wr_ptr_q] <= new_entry_c;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         fill_q     <= '0;
         edge_q     <= 1'b0;
         armed_q    <= 1'b0;
         first_q    <= 1'b1;
         last_ts_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ts_valid   <= 1'b0;
         ts_stamp   <= '0;
         ts_delta   <= '0;
         ts_first   <= 1'b0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], event_in};
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         edge_q  <= sync_q[SYNC_STAGES-1];
         if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
            armed_q <= 1'b1;
         end
         if (detect_c) begin
            first_q   <= 1'b0;
            last_ts_q <= counter[30:0];
         end
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q   <= rd_ptr_nxt_c;
         count_q    <= count_nxt_c;
         fifo_level <= count_nxt_c;
         ts_valid   <= (count_nxt_c != '0);
         ts_stamp   <= {1'b0, head_nxt_c.stamp};
         ts_delta   <= {1'b0, head_nxt_c.delta};
         ts_first   <= head_nxt_c.first;
         // A drop in the same cycle as a clear wins: it restarts the count at one.
         if (drop_c) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
               drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: event stamping, deltas, wrap, overflow,
// simultaneous push/pop, clear/drop priority and asynchronous reset.
module tb_timestamp_capture;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] counter;
   logic        event_in;
   logic        clear_ovf;
   logic        ts_valid;
   logic        ts_ready;
   logic [31:0] ts_stamp;
   logic [31:0] ts_delta;
   logic        ts_first;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic [7:0]  drop_count;

   int passed = 0;
   int total  = 0;

   timestamp_capture #(.DEPTH(4), .SYNC_STAGES(2)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .counter    (counter),
      .event_in   (event_in),
      .clear_ovf  (clear_ovf),
      .ts_valid   (ts_valid),
      .ts_ready   (ts_ready),
      .ts_stamp   (ts_stamp),
      .ts_delta   (ts_delta),
      .ts_first   (ts_first),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Rising edge on event_in with the timebase held at c; returns at a negedge once captured.
   task automatic fire(input logic [31:0] c);
      @(negedge clock);
      counter  = c;
      event_in = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      event_in = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic head(input string tag, input logic [31:0] s, input logic [31:0] d, input logic f);
      check({tag, "_valid"}, 32'(ts_valid), 32'd1);
      check({tag, "_stamp"}, ts_stamp, s);
      check({tag, "_delta"}, ts_delta, d);
      check({tag, "_first"}, 32'(ts_first), 32'(f));
   endtask

   task automatic pop();
      @(negedge clock);
      ts_ready = 1'b1;
      @(negedge clock);
      ts_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; counter = '0; event_in = 1'b0; clear_ovf = 1'b0; ts_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_valid", 32'(ts_valid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_drops", 32'(drop_count), 32'd0);
      check("rst_stamp", ts_stamp, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // Single event with latency check: captured on the third edge after the input rises.
      counter = 32'd100; event_in = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("lat_not_yet", 32'(ts_valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      head("ev1", 32'd100, 32'd0, 1'b1);
      check("ev1_level", 32'(fifo_level), 32'd1);
      event_in = 1'b0;
      repeat (3) @(negedge clock);
      pop();
      check("pop_empty", 32'(ts_valid), 32'd0);

      fire(32'd350);
      head("ev2", 32'd350, 32'd250, 1'b0);
      pop();
      fire(32'd2147483640);
      head("wrap_a", 32'd2147483640, 32'd2147483290, 1'b0);
      pop();
      fire(32'd5);
      head("wrap_b", 32'd5, 32'd13, 1'b0);
      pop();
      fire(32'h8000_0014);
      head("bit31", 32'd20, 32'd15, 1'b0);
      pop();
      check("drained", 32'(fifo_level), 32'd0);

      // Six events into a four-entry FIFO with no consumer.
      for (int i = 0; i < 6; i++) fire(32'd1000 + 32'(i * 10));
      check("ovf_level", 32'(fifo_level), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_drops", 32'(drop_count), 32'd2);
      @(negedge clock); clear_ovf = 1'b1;
      @(negedge clock); clear_ovf = 1'b0;
      check("clr_flag", 32'(overflow), 32'd0);
      check("clr_drops", 32'(drop_count), 32'd0);
      check("clr_level", 32'(fifo_level), 32'd4);
      head("clr_head", 32'd1000, 32'd980, 1'b0);

      // Full FIFO: capture and pop on the same edge.
      @(negedge clock); counter = 32'd2000; event_in = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock); ts_ready = 1'b1;
      @(negedge clock); ts_ready = 1'b0;
      check("pp_level", 32'(fifo_level), 32'd4);
      check("pp_flag", 32'(overflow), 32'd0);
      check("pp_drops", 32'(drop_count), 32'd0);
      event_in = 1'b0;
      repeat (3) @(negedge clock);
      head("pp_h1", 32'd1010, 32'd10, 1'b0);
      pop();
      head("pp_h2", 32'd1020, 32'd10, 1'b0);
      pop();
      head("pp_h3", 32'd1030, 32'd10, 1'b0);
      pop();
      head("pp_tail", 32'd2000, 32'd950, 1'b0);
      pop();
      check("pp_drained", 32'(ts_valid), 32'd0);

      // Asynchronous reset with entries stored.
      fire(32'd3000); fire(32'd3100); fire(32'd3200);
      check("mid_level", 32'(fifo_level), 32'd3);
      @(posedge clock); #2;
      reset_n = 1'b0;
      #1;
      check("async_valid", 32'(ts_valid), 32'd0);
      check("async_level", 32'(fifo_level), 32'd0);
      @(negedge clock); reset_n = 1'b1;
      repeat (5) @(negedge clock);
      fire(32'd4000);
      head("post_rst", 32'd4000, 32'd0, 1'b1);
      pop();

      // Line already high at reset release is not an event.
      @(negedge clock); reset_n = 1'b0; event_in = 1'b1;
      @(negedge clock); reset_n = 1'b1;
      repeat (8) @(negedge clock);
      check("high_at_rel", 32'(fifo_level), 32'd0);
      event_in = 1'b0;
      repeat (4) @(negedge clock);
      fire(32'd5000);
      head("after_high", 32'd5000, 32'd0, 1'b1);

      // Clear and drop on the same edge: the drop wins.
      fire(32'd5100); fire(32'd5200); fire(32'd5300);
      check("cd_level", 32'(fifo_level), 32'd4);
      @(negedge clock); counter = 32'd5400; event_in = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock); clear_ovf = 1'b1;
      @(negedge clock); clear_ovf = 1'b0;
      check("cd_flag", 32'(overflow), 32'd1);
      check("cd_drops", 32'(drop_count), 32'd1);
      event_in = 1'b0;
      repeat (3) @(negedge clock);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
